// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC SPM output-side display stage.
// Provides the glyph code type, the display mode type, active-low segment
// patterns (bit order g..a) for every glyph, and default parameters.
package risc_spm_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 50000;
  localparam int unsigned CYC_W_DEFAULT    = 16;
  localparam int unsigned GLYPH_W          = 5;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned DIGITS           = 4;

  // Glyph codes: 0x00-0x0F hex digits, 0x10 'H', 0x11 '-'
  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t GLYPH_H    = 5'h10;
  localparam glyph_t GLYPH_DASH = 5'h11;

  // Display view selected by the mode key
  typedef enum logic {
    MODE_PORT  = 1'b0,
    MODE_COUNT = 1'b1
  } mode_t;

  // Active-low segment patterns, bit6 = g ... bit0 = a
  localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A    = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B    = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C    = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D    = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F    = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_H    = 7'h09;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

  // Hex nibble to glyph code
  function automatic glyph_t hex_glyph(input logic [3:0] nib);
    return glyph_t'(nib);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to 7-segment decoder.
// Ports:
//   code  - 5-bit glyph code (hex 0-F, 'H', '-')
//   seg_c - active-low segments, bit6 = g ... bit0 = a; unknown codes blank
module seg7_decode
  import risc_spm_pkg::*;
(
  input  glyph_t           code,
  output logic [SEG_W-1:0] seg_c
);

  // Glyph lookup, unknown codes drive all segments off
  always_comb begin
    seg_c = SEG_OFF;
    case (code)
      5'h00:      seg_c = SEG_0;
      5'h01:      seg_c = SEG_1;
      5'h02:      seg_c = SEG_2;
      5'h03:      seg_c = SEG_3;
      5'h04:      seg_c = SEG_4;
      5'h05:      seg_c = SEG_5;
      5'h06:      seg_c = SEG_6;
      5'h07:      seg_c = SEG_7;
      5'h08:      seg_c = SEG_8;
      5'h09:      seg_c = SEG_9;
      5'h0A:      seg_c = SEG_A;
      5'h0B:      seg_c = SEG_B;
      5'h0C:      seg_c = SEG_C;
      5'h0D:      seg_c = SEG_D;
      5'h0E:      seg_c = SEG_E;
      5'h0F:      seg_c = SEG_F;
      GLYPH_H:    seg_c = SEG_H;
      GLYPH_DASH: seg_c = SEG_DASH;
      default:    seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/risc_spm_disp.sv
// Output-side stage for the RISC SPM core: registers the core ports, latches
// halt, counts run cycles and scans a 4-digit common-anode 7-segment display.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   p0, p1     - core output ports (8 and 4 bits)
//   halt       - core halt indication
//   mode_key   - asynchronous key level, high = pressed; each press toggles view
//   seg        - active-low segments, bit7 = dp, bits6..0 = g..a
//   sel        - active-low one-hot digit select, bit0 = rightmost digit
//   halt_led   - sticky halt indicator
//   run_cycles - cycles counted while the core was running (saturating)
module risc_spm_disp
  import risc_spm_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int unsigned CYC_W    = CYC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       p0,
  input  logic [3:0]       p1,
  input  logic             halt,
  input  logic             mode_key,
  output logic [7:0]       seg,
  output logic [3:0]       sel,
  output logic             halt_led,
  output logic [CYC_W-1:0] run_cycles
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned EXT_W  = (CYC_W > 16) ? CYC_W : 16;

  // Registered state
  logic [7:0]        p0_q;
  logic [3:0]        p1_q;
  logic              halt_q;
  logic              key_s1, key_s2, key_s3;
  mode_t             mode;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;

  // Next-state values
  mode_t             mode_d;
  logic [SCAN_W-1:0] scan_d;
  logic [1:0]        digit_d;
  logic              halt_led_d;
  logic [CYC_W-1:0]  run_d;
  logic [7:0]        seg_d;
  logic [3:0]        sel_d;

  // Combinational helpers
  logic              key_rise_c;
  logic              scan_wrap_c;
  logic [EXT_W-1:0]  cyc_ext_c;
  glyph_t            glyph_c;
  logic              dp_on_c;
  logic [SEG_W-1:0]  seg7_c;

  seg7_decode u_dec (
    .code  (glyph_c),
    .seg_c (seg7_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q       <= '0;
      p1_q       <= '0;
      halt_q     <= 1'b0;
      key_s1     <= 1'b0;
      key_s2     <= 1'b0;
      key_s3     <= 1'b0;
      mode       <= MODE_PORT;
      scan_cnt   <= '0;
      digit_idx  <= '0;
      halt_led   <= 1'b0;
      run_cycles <= '0;
      seg        <= 8'hFF;
      sel        <= 4'hF;
    end else begin
      p0_q       <= p0;
      p1_q       <= p1;
      halt_q     <= halt;
      key_s1     <= mode_key;
      key_s2     <= key_s1;
      key_s3     <= key_s2;
      mode       <= mode_d;
      scan_cnt   <= scan_d;
      digit_idx  <= digit_d;
      halt_led   <= halt_led_d;
      run_cycles <= run_d;
      seg        <= seg_d;
      sel        <= sel_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    key_rise_c  = 1'b0;
    scan_wrap_c = 1'b0;
    cyc_ext_c   = EXT_W'(run_cycles);
    glyph_c     = GLYPH_DASH;
    dp_on_c     = 1'b0;
    mode_d      = mode;
    scan_d      = scan_cnt + SCAN_W'(1);
    digit_d     = digit_idx;
    halt_led_d  = halt_led | halt_q;
    run_d       = run_cycles;
    seg_d       = 8'hFF;
    sel_d       = 4'hF;

    // Rising edge of the synchronized key toggles the view; bounces toggle too
    key_rise_c = key_s2 & ~key_s3;
    if (key_rise_c) begin
      mode_d = (mode == MODE_PORT) ? MODE_COUNT : MODE_PORT;
    end

    // Digit slot timer
    scan_wrap_c = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    if (scan_wrap_c) begin
      scan_d  = '0;
      digit_d = digit_idx + 2'd1;
    end

    // Count only while running; the halt cycle itself is not counted
    if (!halt_led && !halt_q && (run_cycles != {CYC_W{1'b1}})) begin
      run_d = run_cycles + CYC_W'(1);
    end

    // Content of the digit currently being driven
    if (mode == MODE_PORT) begin
      case (digit_idx)
        2'd0:    glyph_c = hex_glyph(p0_q[3:0]);
        2'd1:    glyph_c = hex_glyph(p0_q[7:4]);
        2'd2:    glyph_c = hex_glyph(p1_q);
        default: glyph_c = halt_led ? GLYPH_H : GLYPH_DASH;
      endcase
    end else begin
      case (digit_idx)
        2'd0:    glyph_c = hex_glyph(cyc_ext_c[3:0]);
        2'd1:    glyph_c = hex_glyph(cyc_ext_c[7:4]);
        2'd2:    glyph_c = hex_glyph(cyc_ext_c[11:8]);
        default: glyph_c = hex_glyph(cyc_ext_c[15:12]);
      endcase
      // dp on the leftmost digit marks the count view
      dp_on_c = (digit_idx == 2'd3);
    end

    seg_d = {~dp_on_c, seg7_c};
    sel_d = ~(4'b0001 << digit_idx);
  end

endmodule

// File: tb/tb_risc_spm_disp.sv
// Directed self-checking bench for risc_spm_disp (SCAN_DIV=4).
// A second instance with CYC_W=4 covers counter saturation.
module tb_risc_spm_disp;
  import risc_spm_pkg::*;

  localparam int unsigned SCAN = 4;

  logic        clk;
  logic        rst, rst2;
  logic [7:0]  p0;
  logic [3:0]  p1;
  logic        halt, halt2;
  logic        mode_key;

  logic [7:0]  seg, seg_sat;
  logic [3:0]  sel, sel_sat;
  logic        halt_led, halt_led_sat;
  logic [15:0] run_cycles;
  logic [3:0]  run_sat;

  int n_pass;
  int n_total;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_seen;

  risc_spm_disp #(.SCAN_DIV(SCAN), .CYC_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0),
    .p1         (p1),
    .halt       (halt),
    .mode_key   (mode_key),
    .seg        (seg),
    .sel        (sel),
    .halt_led   (halt_led),
    .run_cycles (run_cycles)
  );

  risc_spm_disp #(.SCAN_DIV(SCAN), .CYC_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst2),
    .p0         (p0),
    .p1         (p1),
    .halt       (halt2),
    .mode_key   (1'b0),
    .seg        (seg_sat),
    .sel        (sel_sat),
    .halt_led   (halt_led_sat),
    .run_cycles (run_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records the last segment value seen for each selected digit over a full scan
  task automatic capture();
    cap_seen = 4'h0;
    for (int i = 0; i < 4; i++) cap_seg[i] = 8'h00;
    repeat (4 * SCAN + 2) begin
      @(negedge clk);
      case (sel)
        4'b1110: begin cap_seg[0] = seg; cap_seen[0] = 1'b1; end
        4'b1101: begin cap_seg[1] = seg; cap_seen[1] = 1'b1; end
        4'b1011: begin cap_seg[2] = seg; cap_seen[2] = 1'b1; end
        4'b0111: begin cap_seg[3] = seg; cap_seen[3] = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0  = 8'h12;
    repeat (6) @(negedge clk);
    // Assert reset between clock edges and look before the next edge
    #2 rst = 1'b1;
    #1;
    n_total++; if (seg !== 8'hFF) $display("FAIL reset_seg got %h want ff", seg); else n_pass++;
    n_total++; if (sel !== 4'hF) $display("FAIL reset_sel got %h want f", sel); else n_pass++;
    n_total++; if (run_cycles !== 16'h0000) $display("FAIL reset_run got %h want 0000", run_cycles); else n_pass++;
    n_total++; if (halt_led !== 1'b0) $display("FAIL reset_halt_led got %b want 0", halt_led); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_port_view();
    logic [3:0] exp_sel [4];
    logic [7:0] exp_seg [4];
    logic [7:0] want;
    exp_sel[0] = 4'b1110; exp_sel[1] = 4'b1101; exp_sel[2] = 4'b1011; exp_sel[3] = 4'b0111;
    exp_seg[0] = 8'h92;   exp_seg[1] = 8'h88;   exp_seg[2] = 8'hB0;   exp_seg[3] = 8'hBF;
    p0 = 8'hA5; p1 = 4'h3; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      // First slot cycle was decoded from the still-reset p0_q (digit 0)
      want = (i == 0) ? 8'hC0 : exp_seg[i/4];
      n_total++; if (sel !== exp_sel[i/4]) $display("FAIL port_sel[%0d] got %b want %b", i, sel, exp_sel[i/4]); else n_pass++;
      n_total++; if (seg !== want) $display("FAIL port_seg[%0d] got %h want %h", i, seg, want); else n_pass++;
    end
  endtask

  task automatic test_halt();
    rst = 1'b1; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (run_cycles !== 16'd9) $display("FAIL halt_pre_run got %0d want 9", run_cycles); else n_pass++;
    halt = 1'b1;
    @(negedge clk);
    // halt only captured so far: counted this cycle, led not yet lit
    n_total++; if (halt_led !== 1'b0) $display("FAIL halt_led_early got %b want 0", halt_led); else n_pass++;
    halt = 1'b0;
    @(negedge clk);
    n_total++; if (run_cycles !== 16'd10) $display("FAIL halt_run got %0d want 10", run_cycles); else n_pass++;
    n_total++; if (halt_led !== 1'b1) $display("FAIL halt_led got %b want 1", halt_led); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if (run_cycles !== 16'd10) $display("FAIL halt_frozen got %0d want 10", run_cycles); else n_pass++;
    n_total++; if (halt_led !== 1'b1) $display("FAIL halt_sticky got %b want 1", halt_led); else n_pass++;
    capture();
    n_total++; if (cap_seen !== 4'hF) $display("FAIL halt_scan_seen got %h want f", cap_seen); else n_pass++;
    n_total++; if (cap_seg[3] !== 8'h89) $display("FAIL halt_d3 got %h want 89", cap_seg[3]); else n_pass++;
    n_total++; if (cap_seg[0] !== 8'h92) $display("FAIL halt_d0 got %h want 92", cap_seg[0]); else n_pass++;
  endtask

  task automatic test_mode_toggle();
    rst = 1'b1; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (299) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    @(negedge clk);
    n_total++; if (run_cycles !== 16'h012C) $display("FAIL mode_run got %h want 012c", run_cycles); else n_pass++;
    mode_key = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (dut.mode !== MODE_PORT) $display("FAIL mode_early got %b want 0", dut.mode); else n_pass++;
    @(negedge clk);
    n_total++; if (dut.mode !== MODE_COUNT) $display("FAIL mode_toggle got %b want 1", dut.mode); else n_pass++;
    mode_key = 1'b0;
    repeat (3) @(negedge clk);
    capture();
    n_total++; if (cap_seen !== 4'hF) $display("FAIL mode_scan_seen got %h want f", cap_seen); else n_pass++;
    n_total++; if (cap_seg[0] !== 8'hC6) $display("FAIL mode_d0 got %h want c6", cap_seg[0]); else n_pass++;
    n_total++; if (cap_seg[1] !== 8'hA4) $display("FAIL mode_d1 got %h want a4", cap_seg[1]); else n_pass++;
    n_total++; if (cap_seg[2] !== 8'hF9) $display("FAIL mode_d2 got %h want f9", cap_seg[2]); else n_pass++;
    n_total++; if (cap_seg[3] !== 8'h40) $display("FAIL mode_d3 got %h want 40", cap_seg[3]); else n_pass++;
    // Second press returns to port view
    mode_key = 1'b1;
    repeat (3) @(negedge clk);
    mode_key = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (dut.mode !== MODE_PORT) $display("FAIL mode_back got %b want 0", dut.mode); else n_pass++;
    capture();
    n_total++; if (cap_seg[3] !== 8'h89) $display("FAIL mode_back_d3 got %h want 89", cap_seg[3]); else n_pass++;
    n_total++; if (cap_seg[0] !== 8'h92) $display("FAIL mode_back_d0 got %h want 92", cap_seg[0]); else n_pass++;
  endtask

  task automatic test_live_update();
    bit found;
    p0 = 8'h00; p1 = 4'h6;
    repeat (2) @(negedge clk);
    capture();
    n_total++; if (cap_seg[0] !== 8'hC0) $display("FAIL live_pre_d0 got %h want c0", cap_seg[0]); else n_pass++;
    n_total++; if (cap_seg[1] !== 8'hC0) $display("FAIL live_pre_d1 got %h want c0", cap_seg[1]); else n_pass++;
    n_total++; if (cap_seg[2] !== 8'h82) $display("FAIL live_pre_d2 got %h want 82", cap_seg[2]); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 4 * SCAN + 4 && !found; i++) begin
      @(negedge clk);
      if (sel === 4'b1110) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL live_wait_d0 got no_slot want sel_1110"); else n_pass++;
    @(negedge clk);
    p0 = 8'hFF;
    capture();
    n_total++; if (cap_seg[0] !== 8'h8E) $display("FAIL live_d0 got %h want 8e", cap_seg[0]); else n_pass++;
    n_total++; if (cap_seg[1] !== 8'h8E) $display("FAIL live_d1 got %h want 8e", cap_seg[1]); else n_pass++;
    n_total++; if (cap_seg[2] !== 8'h82) $display("FAIL live_d2 got %h want 82", cap_seg[2]); else n_pass++;
    n_total++; if (cap_seg[3] !== 8'h89) $display("FAIL live_d3 got %h want 89", cap_seg[3]); else n_pass++;
  endtask

  task automatic test_saturation();
    halt2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (7) @(negedge clk);
    n_total++; if (run_sat !== 4'd7) $display("FAIL sat_mid got %h want 7", run_sat); else n_pass++;
    repeat (8) @(negedge clk);
    n_total++; if (run_sat !== 4'hF) $display("FAIL sat_full got %h want f", run_sat); else n_pass++;
    repeat (13) @(negedge clk);
    n_total++; if (run_sat !== 4'hF) $display("FAIL sat_hold got %h want f", run_sat); else n_pass++;
    n_total++; if (halt_led_sat !== 1'b0) $display("FAIL sat_halt_led got %b want 0", halt_led_sat); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    rst2     = 1'b1;
    p0       = 8'h00;
    p1       = 4'h0;
    halt     = 1'b0;
    halt2    = 1'b0;
    mode_key = 1'b0;
    test_reset();
    test_port_view();
    test_halt();
    test_mode_toggle();
    test_live_update();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
